adder_tree_pipelined: RTL and testbench

Parametrised successor to the single two-operand adder. Reduces N_INPUTS signed operands to one sum through a registered binary tree, one register level per tree level. Optional output scaling and width reduction. Valid/ready handshake on both sides, so it drops into the accumulator/PE datapath as a streaming stage and removes the long combinational adder chain from the critical path.

---
 rtl/adder_tree_pkg.sv | 41 ++++
 rtl/adder_tree_pipelined_if.sv | 39 +++
 rtl/adder_tree_level.sv | 46 ++++
 rtl/adder_tree_pipelined.sv | 66 ++++++
 tb/tb_adder_tree_pipelined.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: level geometry and
// saturating resize used by the output stage.
package adder_tree_pkg;

  function automatic int tree_levels(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int level_count(input int n, input int i);
    int c;
    c = n;
    for (int k = 0; k < i; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Bit offset of level i inside the flattened tree vector
  function automatic int level_offset(
    input int n,
    input int w,
    input int i
  );
    int o;
    o = 0;
    for (int k = 0; k < i; k++) o += level_count(n, k) * (w + k);
    return o;
  endfunction

  function automatic logic signed [63:0] sat_resize(
    input logic signed [63:0] x,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/adder_tree_pipelined_if.sv
// Streaming bundle of the adder tree: operand vector in, scaled sum out,
// plus the pipeline occupancy flag.
interface adder_tree_pipelined_if
  import adder_tree_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = IN_WIDTH + tree_levels(N_INPUTS)
);

  logic [N_INPUTS*IN_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [OUT_WIDTH-1:0]         out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output busy
  );

endinterface

// File: rtl/adder_tree_level.sv
// One tree level: pairwise sign-extended adds into a register bank
// with its valid bit, all gated by the shared advance enable.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W_IN = 8
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic                               advance,
  input  logic                               vin,
  input  logic [N_IN*W_IN-1:0]               d,
  output logic                               vout,
  output logic [((N_IN+1)/2)*(W_IN+1)-1:0]   q
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int W_OUT = W_IN + 1;

  logic [N_OUT*W_OUT-1:0] sum;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic signed [W_OUT-1:0] a;
    assign a = {d[(2*j+1)*W_IN-1], d[2*j*W_IN +: W_IN]};
    if (2 * j + 1 < N_IN) begin : g_add
      logic signed [W_OUT-1:0] b;
      assign b = {d[(2*j+2)*W_IN-1], d[(2*j+1)*W_IN +: W_IN]};
      assign sum[j*W_OUT +: W_OUT] = a + b;
    end else begin : g_pass
      // Odd element rides through with one extra sign bit
      assign sum[j*W_OUT +: W_OUT] = a;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      q    <= '0;
      vout <= 1'b0;
    end else if (advance) begin
      q    <= sum;
      vout <= vin;
    end
  end

endmodule

// File: rtl/adder_tree_pipelined.sv
// Registered binary adder tree with valid/ready streaming and global stall.
// Define ADDER_TREE_SATURATE_EN to clamp instead of wrap on width reduction.
module adder_tree_pipelined
  import adder_tree_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = IN_WIDTH + tree_levels(N_INPUTS),
  parameter int OUT_SCALE = 0
) (
  input logic                   clk,
  input logic                   arst,
  adder_tree_pipelined_if.slave bus
);

  localparam int LEVELS     = tree_levels(N_INPUTS);
  localparam int FULL_WIDTH = IN_WIDTH + LEVELS;
  localparam int TOTAL      =
    level_offset(N_INPUTS, IN_WIDTH, LEVELS + 1);

  logic                         advance;
  logic [LEVELS:0]              vld;
  logic [TOTAL-1:0]             tree;
  logic signed [FULL_WIDTH-1:0] full_sum;

  assign advance     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  assign vld[0] = bus.in_valid;
  assign tree[N_INPUTS*IN_WIDTH-1:0] = bus.in_data;

  for (genvar i = 1; i <= LEVELS; i++) begin : g_lvl
    localparam int NI  = level_count(N_INPUTS, i - 1);
    localparam int NO  = level_count(N_INPUTS, i);
    localparam int WI  = IN_WIDTH + i - 1;
    localparam int OFI = level_offset(N_INPUTS, IN_WIDTH, i - 1);
    localparam int OFO = level_offset(N_INPUTS, IN_WIDTH, i);

    adder_tree_level #(
      .N_IN (NI),
      .W_IN (WI)
    ) u_level (
      .clk     (clk),
      .arst    (arst),
      .advance (advance),
      .vin     (vld[i-1]),
      .d       (tree[OFI +: NI*WI]),
      .vout    (vld[i]),
      .q       (tree[OFO +: NO*(WI+1)])
    );
  end

  assign full_sum = tree[TOTAL-1 -: FULL_WIDTH];

  // Arithmetic shift floors toward -inf before the width change
`ifdef ADDER_TREE_SATURATE_EN
  assign bus.out_data = OUT_WIDTH'(
    sat_resize(64'(full_sum >>> OUT_SCALE), OUT_WIDTH));
`else
  assign bus.out_data = OUT_WIDTH'(full_sum >>> OUT_SCALE);
`endif

  assign bus.out_valid = vld[LEVELS];
  assign bus.busy      = |vld[LEVELS:1];

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Directed bench for adder_tree_pipelined over several geometries,
// backpressure, random ready against a queue, and async reset.
module tb_adder_tree_pipelined;

  logic clk;
  logic arst;
  int   n_checks;
  int   n_errors;

`ifdef ADDER_TREE_SATURATE_EN
  localparam int EXP_W9_LO = -256;
  localparam int EXP_W9_HI = 255;
`else
  localparam int EXP_W9_LO = 0;
  localparam int EXP_W9_HI = -4;
`endif

  adder_tree_pipelined_if #(.N_INPUTS(4), .IN_WIDTH(8), .OUT_WIDTH(10)) a4 ();
  adder_tree_pipelined_if #(.N_INPUTS(3), .IN_WIDTH(8), .OUT_WIDTH(10)) a3 ();
  adder_tree_pipelined_if #(.N_INPUTS(4), .IN_WIDTH(8), .OUT_WIDTH(9))  a9 ();
  adder_tree_pipelined_if #(.N_INPUTS(2), .IN_WIDTH(8), .OUT_WIDTH(9))  as ();
  adder_tree_pipelined_if #(.N_INPUTS(1), .IN_WIDTH(8), .OUT_WIDTH(9))  a1 ();

  adder_tree_pipelined #(.N_INPUTS(4), .IN_WIDTH(8)) u4 (
    .clk (clk), .arst (arst), .bus (a4));
  adder_tree_pipelined #(.N_INPUTS(3), .IN_WIDTH(8)) u3 (
    .clk (clk), .arst (arst), .bus (a3));
  adder_tree_pipelined #(.N_INPUTS(4), .IN_WIDTH(8), .OUT_WIDTH(9)) u9 (
    .clk (clk), .arst (arst), .bus (a9));
  adder_tree_pipelined #(.N_INPUTS(2), .IN_WIDTH(8), .OUT_SCALE(1)) us (
    .clk (clk), .arst (arst), .bus (as));
  adder_tree_pipelined #(.N_INPUTS(1), .IN_WIDTH(8)) u1 (
    .clk (clk), .arst (arst), .bus (a1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string              tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_stream(input int nvec, input int mode);
    int         q[$];
    int         ops[4];
    int         tbl[6][4];
    int         sent;
    int         got;
    int         held;
    int         s;
    logic       hv;
    logic [7:0] b;
    tbl = '{'{1, 2, 3, 4}, '{-5, 6, -7, 8}, '{127, 127, 127, 127},
            '{-128, -128, -128, -128}, '{10, -20, 30, -40}, '{0, 0, 0, 1}};
    sent = 0;
    got  = 0;
    hv   = 1'b0;
    held = 0;
    for (int cyc = 0; cyc < nvec * 4 + 50 && got < nvec; cyc++) begin
      @(negedge clk);
      if (mode == 0) a4.out_ready = !(cyc >= 4 && cyc < 9);
      else           a4.out_ready = 1'($urandom_range(0, 1));
      if (sent < nvec) begin
        for (int k = 0; k < 4; k++) begin
          if (mode == 0) ops[k] = tbl[sent][k];
          else begin
            b = 8'($urandom_range(0, 255));
            ops[k] = int'($signed(b));
          end
        end
        a4.in_data  = {8'(ops[3]), 8'(ops[2]), 8'(ops[1]), 8'(ops[0])};
        a4.in_valid = 1'b1;
      end else begin
        a4.in_valid = 1'b0;
      end
      #1;
      if (mode == 0 && !a4.out_ready) begin
        chk("stall_vld", a4.out_valid, 1);
        chk("stall_rdy", a4.in_ready, 0);
        if (hv) chk("stall_data", $signed(a4.out_data), held);
        held = $signed(a4.out_data);
        hv   = 1'b1;
      end
      if (a4.out_valid && a4.out_ready) begin
        if (q.size() == 0) chk("dup", 1, 0);
        else chk("seq", $signed(a4.out_data), q.pop_front());
        got++;
      end
      if (a4.in_valid && a4.in_ready) begin
        s = ops[0] + ops[1] + ops[2] + ops[3];
        q.push_back(s);
        sent++;
      end
    end
    chk("stream_cnt", got, nvec);
    chk("stream_left", q.size(), 0);
    @(negedge clk);
    a4.in_valid  = 1'b0;
    a4.out_ready = 1'b1;
  endtask

  initial begin
    int n_out;
    n_checks = 0;
    n_errors = 0;
    arst = 1'b1;
    a4.in_valid = 0; a4.in_data = '0; a4.out_ready = 1;
    a3.in_valid = 0; a3.in_data = '0; a3.out_ready = 1;
    a9.in_valid = 0; a9.in_data = '0; a9.out_ready = 1;
    as.in_valid = 0; as.in_data = '0; as.out_ready = 1;
    a1.in_valid = 0; a1.in_data = '0; a1.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_vld", a4.out_valid, 0);
    chk("rst_data", $signed(a4.out_data), 0);
    chk("rst_busy", a4.busy, 0);
    chk("rst_rdy", a4.in_ready, 1);
    arst = 1'b0;

    @(negedge clk);
    a4.in_data = {8'd4, 8'd3, 8'd2, 8'd1};
    a3.in_data = {8'd7, 8'hfd, 8'd5};
    a9.in_data = {8'h80, 8'h80, 8'h80, 8'h80};
    as.in_data = {8'hfd, 8'hfe};
    a1.in_data = 8'hfb;
    {a4.in_valid, a3.in_valid, a9.in_valid, as.in_valid, a1.in_valid} = '1;
    @(negedge clk);
    chk("n4_lat1_vld", a4.out_valid, 0);
    chk("n4_busy", a4.busy, 1);
    chk("sc_vld", as.out_valid, 1);
    chk("sc_neg", $signed(as.out_data), -3);
    chk("n1_neg", $signed(a1.out_data), -5);
    a4.in_data = {8'hff, 8'hff, 8'hff, 8'hff};
    a3.in_data = {8'h80, 8'h80, 8'h80};
    a9.in_data = {8'h7f, 8'h7f, 8'h7f, 8'h7f};
    as.in_data = {8'd3, 8'd2};
    a1.in_data = 8'd100;
    @(negedge clk);
    chk("n4_lat2_vld", a4.out_valid, 1);
    chk("n4_sum10", $signed(a4.out_data), 10);
    chk("n3_sum9", $signed(a3.out_data), 9);
    chk("w9_neg", $signed(a9.out_data), EXP_W9_LO);
    chk("sc_pos", $signed(as.out_data), 2);
    chk("n1_pos", $signed(a1.out_data), 100);
    {a4.in_valid, a3.in_valid, a9.in_valid, as.in_valid, a1.in_valid} = '0;
    @(negedge clk);
    chk("n4_b2b_vld", a4.out_valid, 1);
    chk("n4_sum_m4", $signed(a4.out_data), -4);
    chk("n3_min", $signed(a3.out_data), -384);
    chk("w9_pos", $signed(a9.out_data), EXP_W9_HI);
    @(negedge clk);
    chk("n4_drain_vld", a4.out_valid, 0);
    chk("n4_drain_busy", a4.busy, 0);

    run_stream(6, 0);
    run_stream(1000, 1);

    @(negedge clk);
    a4.in_data  = {8'd4, 8'd3, 8'd2, 8'd1};
    a4.in_valid = 1'b1;
    @(negedge clk);
    a4.in_data = {8'd9, 8'd9, 8'd9, 8'd9};
    @(negedge clk);
    a4.in_valid = 1'b0;
    #1;
    chk("pre_rst_busy", a4.busy, 1);
    arst = 1'b1;
    #1;
    chk("arst_vld", a4.out_valid, 0);
    chk("arst_data", $signed(a4.out_data), 0);
    chk("arst_busy", a4.busy, 0);
    @(negedge clk);
    arst = 1'b0;
    a4.in_data  = {8'd1, 8'd1, 8'd1, 8'd1};
    a4.in_valid = 1'b1;
    n_out = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a4.in_valid = 1'b0;
      #1;
      if (a4.out_valid) begin
        n_out++;
        chk("post_rst_out", $signed(a4.out_data), 4);
      end
    end
    chk("post_rst_cnt", n_out, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
